// File: rtl/gray_counter_pkg.sv
// Shared helpers for Gray-coded counters: all-ones constant and
// binary/Gray conversions sized to the widest supported counter.
package gray_pkg;

  localparam int unsigned MAX_W = 32;

  function automatic logic [MAX_W-1:0] all_ones(input int unsigned w);
    logic [63:0] t;
    t = (64'd1 << w) - 64'd1;
    return t[MAX_W-1:0];
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and status bundle of the Gray counter; the counter is the slave.
interface gray_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             En_I;
  logic             Up_I;
  logic             Load_I;
  logic [WIDTH-1:0] Load_Val_I;
  logic [WIDTH-1:0] Bin_O;
  logic [WIDTH-1:0] Gray_O;
  logic             Tc_O;
  logic             Wrap_O;

  modport master (
    output En_I, Up_I, Load_I, Load_Val_I,
    input  Bin_O, Gray_O, Tc_O, Wrap_O
  );

  modport slave (
    input  En_I, Up_I, Load_I, Load_Val_I,
    output Bin_O, Gray_O, Tc_O, Wrap_O
  );
endinterface

// File: rtl/gray_counter_binary_gray.sv
// Combinational binary-to-Gray converter.
module gray_counter_binary_gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_counter.sv
// Up/down counter holding a binary count plus a registered Gray copy,
// with load, wrap-or-saturate end handling and wrap/terminal-count flags.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter bit               WRAP    = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic         Clk_I,
  input  logic         Rst_n_I,
  gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONES     = WIDTH'(all_ones(WIDTH));
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;
  logic             at_end;

  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    at_end    = bus.Up_I ? (bin_q == ONES) : (bin_q == '0);
    if (bus.Load_I) begin
      bin_next = bus.Load_Val_I;
    end else if (bus.En_I) begin
      if (!at_end) begin
        bin_next = bus.Up_I ? (bin_q + ONE) : (bin_q - ONE);
      end else if (WRAP) begin
        bin_next  = bus.Up_I ? '0 : ONES;
        wrap_next = 1'b1;
      end
    end
  end

  // Gray register is fed from the next binary value so both registers agree every cycle.
  gray_counter_binary_gray #(.WIDTH(WIDTH)) u_conv (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge Clk_I or negedge Rst_n_I) begin
    if (!Rst_n_I) begin
      bin_q  <= RST_VAL;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      wrap_q <= wrap_next;
    end
  end

  assign bus.Bin_O  = bin_q;
  assign bus.Gray_O = gray_q;
  assign bus.Wrap_O = wrap_q;
  assign bus.Tc_O   = at_end;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: vector table, hand sequences and a randomized
// run against an arithmetic reference model.
module tb_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;

  gray_counter_if #(.WIDTH(4)) if_a ();
  gray_counter_if #(.WIDTH(4)) if_b ();
  gray_counter_if #(.WIDTH(6)) if_c ();

  gray_counter #(.WIDTH(4), .WRAP(1'b1), .RST_VAL(4'd0)) u_a (
    .Clk_I(clk), .Rst_n_I(rst_a), .bus(if_a));
  gray_counter #(.WIDTH(4), .WRAP(1'b0), .RST_VAL(4'd5)) u_b (
    .Clk_I(clk), .Rst_n_I(rst_b), .bus(if_b));
  gray_counter #(.WIDTH(6), .WRAP(1'b1), .RST_VAL(6'd0)) u_c (
    .Clk_I(clk), .Rst_n_I(rst_c), .bus(if_c));

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lval;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
    logic       tc;
  } vec_t;

  function automatic vec_t mk(input logic load, input logic en, input logic up,
                              input logic [3:0] lval, input logic [3:0] bin,
                              input logic [3:0] gray, input logic wrap, input logic tc);
    vec_t v;
    v.load = load; v.en = en; v.up = up; v.lval = lval;
    v.bin = bin; v.gray = gray; v.wrap = wrap; v.tc = tc;
    return v;
  endfunction

  logic [3:0] gray4 [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                             4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   m;
    int   nx;
    logic ld, en, up, w;
    logic [5:0] lv;
    logic [5:0] prev_gray;

    if_a.En_I = 0; if_a.Up_I = 0; if_a.Load_I = 0; if_a.Load_Val_I = '0;
    if_b.En_I = 0; if_b.Up_I = 0; if_b.Load_I = 0; if_b.Load_Val_I = '0;
    if_c.En_I = 0; if_c.Up_I = 0; if_c.Load_I = 0; if_c.Load_Val_I = '0;

    // free-run up through the wrap
    for (int k = 1; k <= 16; k++)
      tbl.push_back(mk(0, 1, 1, 4'd0, 4'(k % 16), gray4[k % 16], k == 16, (k % 16) == 15));
    // load 3, count down through the wrap
    tbl.push_back(mk(1, 0, 0, 4'd3, 4'd3, 4'd2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 4'd2, 4'd3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 4'd1, 4'd1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 4'd0, 4'd0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 4'd0, 4'd15, 4'd8, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 4'd14, 4'd9, 0, 0));
    // load beats enable, then enable alone
    tbl.push_back(mk(1, 0, 1, 4'd4, 4'd4, 4'd6, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'd9, 4'd9, 4'd13, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'd0, 4'd10, 4'd15, 0, 0));
    // wrap from a loaded all-ones, then hold clears the pulse
    tbl.push_back(mk(1, 0, 1, 4'd15, 4'd15, 4'd8, 0, 1));
    tbl.push_back(mk(0, 1, 1, 4'd0, 4'd0, 4'd0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 1));
    // load at a would-be down wrap suppresses the wrap
    tbl.push_back(mk(1, 1, 0, 4'd5, 4'd5, 4'd7, 0, 0));

    repeat (2) tick();
    check("a.rst.bin", if_a.Bin_O, 0);
    check("a.rst.gray", if_a.Gray_O, 0);
    check("a.rst.wrap", if_a.Wrap_O, 0);
    check("b.rst.bin", if_b.Bin_O, 5);
    check("b.rst.gray", if_b.Gray_O, 7);
    check("c.rst.bin", if_c.Bin_O, 0);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();

    foreach (tbl[i]) begin
      if_a.Load_I = tbl[i].load; if_a.En_I = tbl[i].en;
      if_a.Up_I = tbl[i].up; if_a.Load_Val_I = tbl[i].lval;
      tick();
      check($sformatf("tbl%0d.bin", i), if_a.Bin_O, tbl[i].bin);
      check($sformatf("tbl%0d.gray", i), if_a.Gray_O, tbl[i].gray);
      check($sformatf("tbl%0d.wrap", i), if_a.Wrap_O, tbl[i].wrap);
      check($sformatf("tbl%0d.tc", i), if_a.Tc_O, tbl[i].tc);
    end
    if_a.Load_I = 0; if_a.En_I = 0;

    // saturating instance: hold at 15 going up
    if_b.Load_I = 1; if_b.Load_Val_I = 4'd14; if_b.Up_I = 1;
    tick();
    check("sat.load.bin", if_b.Bin_O, 14);
    check("sat.load.gray", if_b.Gray_O, 9);
    if_b.Load_I = 0; if_b.En_I = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("sat.up%0d.bin", k), if_b.Bin_O, 15);
      check($sformatf("sat.up%0d.gray", k), if_b.Gray_O, 8);
      check($sformatf("sat.up%0d.wrap", k), if_b.Wrap_O, 0);
      check($sformatf("sat.up%0d.tc", k), if_b.Tc_O, 1);
    end
    // hold at 0 going down
    if_b.Load_I = 1; if_b.Load_Val_I = 4'd1; if_b.Up_I = 0;
    tick();
    if_b.Load_I = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("sat.dn%0d.bin", k), if_b.Bin_O, 0);
      check($sformatf("sat.dn%0d.wrap", k), if_b.Wrap_O, 0);
      check($sformatf("sat.dn%0d.tc", k), if_b.Tc_O, 1);
    end

    // asynchronous reset between edges while counting
    if_b.Load_I = 1; if_b.Load_Val_I = 4'd6; if_b.Up_I = 1;
    tick();
    if_b.Load_I = 0;
    tick();
    check("arst.pre.bin", if_b.Bin_O, 7);
    #3 rst_b = 1'b0;
    #1;
    check("arst.now.bin", if_b.Bin_O, 5);
    check("arst.now.gray", if_b.Gray_O, 7);
    tick();
    check("arst.held.bin", if_b.Bin_O, 5);
    #2 rst_b = 1'b1;
    tick();
    check("arst.resume1.bin", if_b.Bin_O, 6);
    check("arst.resume1.gray", if_b.Gray_O, 5);
    tick();
    check("arst.resume2.bin", if_b.Bin_O, 7);
    if_b.En_I = 0;

    // randomized run on the 6-bit wrapping instance
    m = 0;
    prev_gray = if_c.Gray_O;
    for (int n = 0; n < 2000; n++) begin
      ld = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 3) != 0);
      up = 1'($urandom_range(0, 1));
      lv = 6'($urandom_range(0, 63));
      if_c.Load_I = ld; if_c.En_I = en; if_c.Up_I = up; if_c.Load_Val_I = lv;
      tick();
      w = 1'b0;
      if (ld) begin
        m = int'(lv);
      end else if (en) begin
        nx = up ? m + 1 : m - 1;
        if (nx < 0 || nx > 63) begin
          nx = (nx + 64) % 64;
          w = 1'b1;
        end
        m = nx;
      end
      check($sformatf("rnd%0d.bin", n), if_c.Bin_O, m);
      check($sformatf("rnd%0d.gray", n), if_c.Gray_O, m ^ (m >> 1));
      check($sformatf("rnd%0d.wrap", n), if_c.Wrap_O, w);
      check($sformatf("rnd%0d.tc", n), if_c.Tc_O, up ? (m == 63) : (m == 0));
      if (!ld)
        check($sformatf("rnd%0d.gray_step", n), $countones(if_c.Gray_O ^ prev_gray) <= 1, 1);
      prev_gray = if_c.Gray_O;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised up/down counter that keeps a binary count and a registered Gray-code copy of it.
- Gray_O changes exactly one bit per count step, so it can be sampled safely across clock domains (e.g. FIFO pointers).
- Adds over the pure converter: sequential state, enable, direction, synchronous load, wrap/saturate mode and a terminal-count/wrap indication.

Parameters:
WIDTH, 4, counter and code width in bits (>= 2)
WRAP, 1, 1 = modulo-2^WIDTH wrap-around; 0 = saturate at the end of range
RST_VAL, 0, binary value loaded on reset (WIDTH bits)

Ports:
Clk_I  input  1  clock, all state updates on rising edge
Rst_n_I  input  1  asynchronous active-low reset
En_I  input  1  count enable, one step per cycle while high
Up_I  input  1  direction: 1 = increment, 0 = decrement
Load_I  input  1  synchronous load strobe
Load_Val_I  input  WIDTH  binary value to load
Bin_O  output  WIDTH  registered binary count
Gray_O  output  WIDTH  registered Gray code of Bin_O
Tc_O  output  1  terminal count: next enabled step in the current direction reaches the end of range
Wrap_O  output  1  one-cycle pulse, registered, after a wrap-around step

Behaviour:
- Reset, asynchronous on Rst_n_I low:
  - Bin_O = RST_VAL, Gray_O = RST_VAL ^ (RST_VAL >> 1), Wrap_O = 0.
  - Takes effect immediately, mid-count or mid-load.
  - First update happens on the first rising edge after deassertion.
- Per-edge priority: Load_I > En_I > hold.
  - Load_I = 1: Bin_O <= Load_Val_I and Gray_O <= gray(Load_Val_I). En_I and Up_I are ignored. Wrap_O <= 0.
  - En_I = 1, Load_I = 0, Up_I = 1:
    - next = Bin_O + 1.
    - At all-ones: WRAP = 1 gives 0 with Wrap_O <= 1; WRAP = 0 holds all-ones with Wrap_O <= 0.
  - En_I = 1, Load_I = 0, Up_I = 0:
    - next = Bin_O - 1.
    - At 0: WRAP = 1 gives all-ones with Wrap_O <= 1; WRAP = 0 holds 0.
  - Otherwise: hold all state, Wrap_O <= 0.
- Gray timing:
  - Gray_O is registered from the next-state binary value, so Bin_O and Gray_O always correspond in the same cycle (latency 1 from En_I/Load_I).
  - No combinational path from any input to Gray_O.
- Tc_O is combinational from state and Up_I only (not En_I):
  - Tc_O = (Up_I && Bin_O == all-ones) || (!Up_I && Bin_O == 0).
- Direction change mid-count: takes effect on the same edge; no idle cycle.
- Width rules: all arithmetic is WIDTH bits, unsigned, with carry/borrow discarded. Wrap detection uses the pre-update value compared against the end value.
- Invariants:
  - Gray_O == Bin_O ^ (Bin_O >> 1) at all times after reset.
  - Across any non-load, non-reset edge, Gray_O changes in exactly 0 or 1 bit position.
  - In WRAP = 0 at the end of range, Gray_O changes in 0 positions.

Decomposition:
- Shared package gray_pkg:
  - function bin2gray(logic [WIDTH-1:0]).
  - function gray2bin (for benches and future synchronizer/FIFO blocks).
  - localparam helpers for the all-ones value.
- Sub-module: instantiate the existing Binary_Gray converter on the next-state binary value to produce the Gray register input.
- Counter logic is a single always_ff plus next-state always_comb. No FSM beyond the count register.

Test Plan:
- Reset/free-run up: RST_VAL = 0, WIDTH = 4, hold Rst_n_I low then release, En_I = 1, Up_I = 1 for 17 cycles.
  - Bin_O 0..15,0 and Gray_O 0000,0001,0011,0010,...,1000,0000.
  - Wrap_O high exactly one cycle, after 15 -> 0.
  - Tc_O high while Bin_O = 15.
- Down wrap: Load 3 then En_I = 1, Up_I = 0 for 5 cycles.
  - Bin_O 3,2,1,0,15,14.
  - Wrap_O pulses once after 0 -> 15.
  - Tc_O high at Bin_O = 0.
- Saturate (WRAP = 0): Load 14, count up 4 cycles.
  - Bin_O 14,15,15,15 and Gray_O stays 1000.
  - Wrap_O never asserts; Tc_O stays high at 15.
- Load priority: Load_I = 1, En_I = 1, Load_Val_I = 9 at Bin_O = 4.
  - Next cycle Bin_O = 9, Gray_O = 1101, Wrap_O = 0.
  - Enable alone, up, next cycle: Bin_O = 10, Gray_O = 1111.
- Async reset mid-count: assert Rst_n_I low between edges at Bin_O = 7 with RST_VAL = 5.
  - Bin_O = 5 and Gray_O = 0111 immediately, before the next clock edge.
  - Counting resumes 5,6 after release.
- Random: 2000 cycles of random En/Up/Load, WIDTH = 6.
  - Scoreboard matches the reference model.
  - Gray single-bit-change assertion holds on every non-load edge.
